control_unit: RTL and testbench

- Moore FSM that sequences the single-bus CPU datapath.
- Drives every datapath enable/select strobe (register in/out, Gra/Grb/Grc, memory Read/write, IncPC, CONin) through fetch, decode and per-opcode execute steps, one step per Clock.
- Reads the instruction from the datapath IR and the branch condition from CON.
- ALU operation selection stays inside the datapath, which decodes IR[31:27].

---
 rtl/control_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the single-bus CPU datapath.
// Walks fetch (T0..T2), decodes the opcode at the T2->T3 edge, then runs the
// per-opcode execute steps. All strobes are registered, so they change only on Clock.
module control_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        HIin,
    output logic        LOin,
    output logic        PCin,
    output logic        MDRin,
    output logic        Zin,
    output logic        Yin,
    output logic        MARin,
    output logic        IRin,
    output logic        CONin,
    output logic        OUTPORTin,
    output logic        HIout,
    output logic        LOout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        PCout,
    output logic        MDRout,
    output logic        INPORTout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        write,
    output logic        IncPC,
    output logic        Run,
    output logic [3:0]  Tstep
);

    typedef enum logic [3:0] {
        StReset, StIdle, StHalt, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7
    } state_e;

    // Execute-phase families; opcodes sharing a step recipe share a class.
    typedef enum logic [3:0] {
        ClsNop, ClsAlu, ClsImm, ClsLdi, ClsMulDiv, ClsUnary, ClsLd, ClsSt,
        ClsBrx, ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsHalt
    } cls_e;

    typedef struct packed {
        logic hi_in;   logic lo_in;   logic pc_in;   logic mdr_in;  logic z_in;
        logic y_in;    logic mar_in;  logic ir_in;   logic con_in;  logic outport_in;
        logic hi_out;  logic lo_out;  logic zhi_out; logic zlo_out; logic pc_out;
        logic mdr_out; logic inport_out; logic c_out;
        logic gra;     logic grb;     logic grc;     logic r_in;    logic r_out;
        logic ba_out;  logic read;    logic write;   logic inc_pc;
    } strobe_t;

    // Index of the last cycle of a stretched memory step.
    localparam logic [1:0] CntLast = 2'(MEM_LAT - 1);

    state_e      state_q, state_d;
    cls_e        cls_q, cls_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        taken_q, taken_d;
    strobe_t     strb_q, strb_d;
    logic        run_q, run_d;
    logic [3:0]  tstep_q, tstep_d;
    logic        mem_last;
    state_e      boundary_st;

    // Only the opcode field matters to the sequencer.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[26:0];

    function automatic cls_e decode_op(logic [4:0] op);
        cls_e c;
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: c = ClsAlu;
            5'b01100, 5'b01101, 5'b01110:           c = ClsImm;
            5'b00001:                               c = ClsLdi;
            5'b01111, 5'b10000:                     c = ClsMulDiv;
            5'b10001, 5'b10010:                     c = ClsUnary;
            5'b00000:                               c = ClsLd;
            5'b00010:                               c = ClsSt;
            5'b10011:                               c = ClsBrx;
            5'b10100:                               c = ClsJr;
            5'b10101:                               c = ClsJal;
            5'b10110:                               c = ClsIn;
            5'b10111:                               c = ClsOut;
            5'b11000:                               c = ClsMfhi;
            5'b11001:                               c = ClsMflo;
            5'b11011:                               c = ClsHalt;
            default:                                c = ClsNop;
        endcase
        return c;
    endfunction

    assign mem_last    = (cnt_q == CntLast);
    // Stop is only honoured when an instruction boundary is reached.
    assign boundary_st = Stop ? StIdle : StT0;

    // Next-state: step sequencing, memory-step stretching and branch sampling.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = '0;
        taken_d = taken_q;
        unique case (state_q)
            StReset: state_d = boundary_st;
            StIdle:  if (!Stop) state_d = StT0;
            StHalt:  state_d = StHalt;
            StT0:    state_d = StT1;
            StT1: begin
                if (!mem_last) cnt_d = cnt_q + 2'd1;
                else           state_d = StT2;
            end
            StT2: begin
                cls_d   = decode_op(IR[31:27]);
                state_d = (cls_d == ClsNop) ? boundary_st : StT3;
            end
            StT3: begin
                case (cls_q)
                    ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo: state_d = boundary_st;
                    ClsHalt: state_d = StHalt;
                    default: state_d = StT4;
                endcase
            end
            StT4: begin
                case (cls_q)
                    ClsUnary, ClsJal: state_d = boundary_st;
                    default:          state_d = StT5;
                endcase
            end
            StT5: begin
                // CON was loaded in T3, so it is settled by the edge into T6.
                taken_d = CON;
                case (cls_q)
                    ClsAlu, ClsImm, ClsLdi: state_d = boundary_st;
                    default:                state_d = StT6;
                endcase
            end
            StT6: begin
                case (cls_q)
                    ClsLd: begin
                        if (!mem_last) cnt_d = cnt_q + 2'd1;
                        else           state_d = StT7;
                    end
                    ClsSt:   state_d = StT7;
                    default: state_d = boundary_st;
                endcase
            end
            StT7: begin
                if (cls_q == ClsSt && !mem_last) cnt_d = cnt_q + 2'd1;
                else                             state_d = boundary_st;
            end
            default: state_d = StReset;
        endcase
    end

    // Strobe decode for the state being entered; registered below.
    always_comb begin
        strb_d  = '0;
        run_d   = 1'b1;
        tstep_d = 4'd0;
        unique case (state_d)
            StReset, StHalt: run_d = 1'b0;
            StIdle: ;
            StT0: begin
                strb_d.pc_out = 1'b1; strb_d.mar_in = 1'b1;
                strb_d.inc_pc = 1'b1; strb_d.z_in   = 1'b1;
            end
            StT1: begin
                tstep_d = 4'd1;
                strb_d.zlo_out = 1'b1; strb_d.read = 1'b1; strb_d.mdr_in = 1'b1;
                strb_d.pc_in   = (cnt_d == 2'd0);
            end
            StT2: begin
                tstep_d = 4'd2;
                strb_d.mdr_out = 1'b1; strb_d.ir_in = 1'b1;
            end
            StT3: begin
                tstep_d = 4'd3;
                case (cls_d)
                    ClsAlu, ClsImm: begin
                        strb_d.grb = 1'b1; strb_d.r_out = 1'b1; strb_d.y_in = 1'b1;
                    end
                    ClsLdi, ClsLd, ClsSt: begin
                        strb_d.grb = 1'b1; strb_d.ba_out = 1'b1; strb_d.y_in = 1'b1;
                    end
                    ClsMulDiv: begin
                        strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.y_in = 1'b1;
                    end
                    ClsUnary: begin
                        strb_d.grb = 1'b1; strb_d.r_out = 1'b1; strb_d.z_in = 1'b1;
                    end
                    ClsBrx: begin
                        strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.con_in = 1'b1;
                    end
                    ClsJr: begin
                        strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.pc_in = 1'b1;
                    end
                    ClsJal: begin
                        strb_d.pc_out = 1'b1; strb_d.grb = 1'b1; strb_d.r_in = 1'b1;
                    end
                    ClsIn: begin
                        strb_d.inport_out = 1'b1; strb_d.gra = 1'b1; strb_d.r_in = 1'b1;
                    end
                    ClsOut: begin
                        strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.outport_in = 1'b1;
                    end
                    ClsMfhi: begin
                        strb_d.hi_out = 1'b1; strb_d.gra = 1'b1; strb_d.r_in = 1'b1;
                    end
                    ClsMflo: begin
                        strb_d.lo_out = 1'b1; strb_d.gra = 1'b1; strb_d.r_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                tstep_d = 4'd4;
                case (cls_d)
                    ClsAlu: begin
                        strb_d.grc = 1'b1; strb_d.r_out = 1'b1; strb_d.z_in = 1'b1;
                    end
                    ClsImm, ClsLdi, ClsLd, ClsSt: begin
                        strb_d.c_out = 1'b1; strb_d.z_in = 1'b1;
                    end
                    ClsMulDiv: begin
                        strb_d.grb = 1'b1; strb_d.r_out = 1'b1; strb_d.z_in = 1'b1;
                    end
                    ClsUnary: begin
                        strb_d.zlo_out = 1'b1; strb_d.gra = 1'b1; strb_d.r_in = 1'b1;
                    end
                    ClsBrx: begin
                        strb_d.pc_out = 1'b1; strb_d.y_in = 1'b1;
                    end
                    ClsJal: begin
                        strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                tstep_d = 4'd5;
                case (cls_d)
                    ClsAlu, ClsImm, ClsLdi: begin
                        strb_d.zlo_out = 1'b1; strb_d.gra = 1'b1; strb_d.r_in = 1'b1;
                    end
                    ClsMulDiv: begin
                        strb_d.zlo_out = 1'b1; strb_d.lo_in = 1'b1;
                    end
                    ClsLd, ClsSt: begin
                        strb_d.zlo_out = 1'b1; strb_d.mar_in = 1'b1;
                    end
                    ClsBrx: begin
                        strb_d.c_out = 1'b1; strb_d.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                tstep_d = 4'd6;
                case (cls_d)
                    ClsMulDiv: begin
                        strb_d.zhi_out = 1'b1; strb_d.hi_in = 1'b1;
                    end
                    ClsLd: begin
                        strb_d.read = 1'b1; strb_d.mdr_in = 1'b1;
                    end
                    ClsSt: begin
                        strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.mdr_in = 1'b1;
                    end
                    ClsBrx: begin
                        strb_d.zlo_out = taken_d; strb_d.pc_in = taken_d;
                    end
                    default: ;
                endcase
            end
            StT7: begin
                tstep_d = 4'd7;
                case (cls_d)
                    ClsLd: begin
                        strb_d.mdr_out = 1'b1; strb_d.gra = 1'b1; strb_d.r_in = 1'b1;
                    end
                    ClsSt:   strb_d.write = 1'b1;
                    default: ;
                endcase
            end
            default: run_d = 1'b0;
        endcase
    end

    // State and registered outputs; Reset low clears everything immediately.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StReset;
            cls_q   <= ClsNop;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            strb_q  <= '0;
            run_q   <= 1'b0;
            tstep_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            strb_q  <= strb_d;
            run_q   <= run_d;
            tstep_q <= tstep_d;
        end
    end

    assign HIin      = strb_q.hi_in;
    assign LOin      = strb_q.lo_in;
    assign PCin      = strb_q.pc_in;
    assign MDRin     = strb_q.mdr_in;
    assign Zin       = strb_q.z_in;
    assign Yin       = strb_q.y_in;
    assign MARin     = strb_q.mar_in;
    assign IRin      = strb_q.ir_in;
    assign CONin     = strb_q.con_in;
    assign OUTPORTin = strb_q.outport_in;
    assign HIout     = strb_q.hi_out;
    assign LOout     = strb_q.lo_out;
    assign ZHIout    = strb_q.zhi_out;
    assign ZLOout    = strb_q.zlo_out;
    assign PCout     = strb_q.pc_out;
    assign MDRout    = strb_q.mdr_out;
    assign INPORTout = strb_q.inport_out;
    assign Cout      = strb_q.c_out;
    assign Gra       = strb_q.gra;
    assign Grb       = strb_q.grb;
    assign Grc       = strb_q.grc;
    assign Rin       = strb_q.r_in;
    assign Rout      = strb_q.r_out;
    assign BAout     = strb_q.ba_out;
    assign Read      = strb_q.read;
    assign write     = strb_q.write;
    assign IncPC     = strb_q.inc_pc;
    assign Run       = run_q;
    assign Tstep     = tstep_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed strobe-sequence checks on three instances
// (MEM_LAT = 1, 3, 4); each instance has its own reset/IR/CON/Stop.
module tb_control_unit;

    // Packed observation word: {Run, Tstep, 27 strobes}.
    localparam logic [31:0] SIncPc     = 32'h0000_0001;
    localparam logic [31:0] SWrite     = 32'h0000_0002;
    localparam logic [31:0] SRead      = 32'h0000_0004;
    localparam logic [31:0] SBaOut     = 32'h0000_0008;
    localparam logic [31:0] SROut      = 32'h0000_0010;
    localparam logic [31:0] SRIn       = 32'h0000_0020;
    localparam logic [31:0] SGrc       = 32'h0000_0040;
    localparam logic [31:0] SGrb       = 32'h0000_0080;
    localparam logic [31:0] SGra       = 32'h0000_0100;
    localparam logic [31:0] SCOut      = 32'h0000_0200;
    localparam logic [31:0] SInportOut = 32'h0000_0400;
    localparam logic [31:0] SMdrOut    = 32'h0000_0800;
    localparam logic [31:0] SPcOut     = 32'h0000_1000;
    localparam logic [31:0] SZloOut    = 32'h0000_2000;
    localparam logic [31:0] SZhiOut    = 32'h0000_4000;
    localparam logic [31:0] SLoOut     = 32'h0000_8000;
    localparam logic [31:0] SHiOut     = 32'h0001_0000;
    localparam logic [31:0] SMarIn     = 32'h0010_0000;
    localparam logic [31:0] SIrIn      = 32'h0008_0000;
    localparam logic [31:0] SConIn     = 32'h0004_0000;
    localparam logic [31:0] SYIn       = 32'h0020_0000;
    localparam logic [31:0] SZIn       = 32'h0040_0000;
    localparam logic [31:0] SMdrIn     = 32'h0080_0000;
    localparam logic [31:0] SPcIn      = 32'h0100_0000;

    // Run=1 with Tstep = n.
    localparam logic [31:0] T0 = 32'h8000_0000;
    localparam logic [31:0] T1 = 32'h8800_0000;
    localparam logic [31:0] T2 = 32'h9000_0000;
    localparam logic [31:0] T3 = 32'h9800_0000;
    localparam logic [31:0] T4 = 32'hA000_0000;
    localparam logic [31:0] T5 = 32'hA800_0000;
    localparam logic [31:0] T6 = 32'hB000_0000;
    localparam logic [31:0] T7 = 32'hB800_0000;

    localparam logic [31:0] F0  = T0 | SPcOut | SMarIn | SIncPc | SZIn;
    localparam logic [31:0] F1  = T1 | SZloOut | SPcIn | SRead | SMdrIn;
    localparam logic [31:0] F1h = T1 | SZloOut | SRead | SMdrIn;
    localparam logic [31:0] F2  = T2 | SMdrOut | SIrIn;
    localparam logic [31:0] Idle = T0;

    localparam logic [31:0] DrvMask = SROut | SBaOut | SCOut | SInportOut | SMdrOut | SPcOut |
                                      SZloOut | SZhiOut | SLoOut | SHiOut;

    localparam logic [31:0] IrAdd  = 32'h1989_0000;
    localparam logic [31:0] IrLd   = 32'h0000_0000;
    localparam logic [31:0] IrSt   = 32'h1000_0000;
    localparam logic [31:0] IrBrx  = 32'h9800_0000;
    localparam logic [31:0] IrJal  = 32'hA800_0000;
    localparam logic [31:0] IrNop  = 32'hD000_0000;
    localparam logic [31:0] IrHalt = 32'hD800_0000;

    logic        clk;
    logic        rst_n [3];
    logic        stop  [3];
    logic        con   [3];
    logic [31:0] ir    [3];
    logic [31:0] obs   [3];

    int n_checks;
    int n_errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic hi_in, lo_in, pc_in, mdr_in, z_in, y_in, mar_in, ir_in, con_in, outport_in;
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
        logic gra, grb, grc, r_in, r_out, ba_out, read, wr, inc_pc, run;
        logic [3:0] tstep;

        control_unit #(.MEM_LAT(Lat)) u_dut (
            .Clock(clk), .Reset(rst_n[g]), .IR(ir[g]), .CON(con[g]), .Stop(stop[g]),
            .HIin(hi_in), .LOin(lo_in), .PCin(pc_in), .MDRin(mdr_in), .Zin(z_in),
            .Yin(y_in), .MARin(mar_in), .IRin(ir_in), .CONin(con_in),
            .OUTPORTin(outport_in), .HIout(hi_out), .LOout(lo_out), .ZHIout(zhi_out),
            .ZLOout(zlo_out), .PCout(pc_out), .MDRout(mdr_out), .INPORTout(inport_out),
            .Cout(c_out), .Gra(gra), .Grb(grb), .Grc(grc), .Rin(r_in), .Rout(r_out),
            .BAout(ba_out), .Read(read), .write(wr), .IncPC(inc_pc), .Run(run),
            .Tstep(tstep)
        );

        assign obs[g] = {run, tstep, hi_in, lo_in, pc_in, mdr_in, z_in, y_in, mar_in, ir_in,
                         con_in, outport_in, hi_out, lo_out, zhi_out, zlo_out, pc_out,
                         mdr_out, inport_out, c_out, gra, grb, grc, r_in, r_out, ba_out,
                         read, wr, inc_pc};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_check(input string tag, input int inst, input logic [31:0] exp);
        check(tag, obs[inst], exp);
        step();
    endtask

    // Single bus driver in every cycle, on every instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            check("one_driver", 32'($countones(obs[i] & DrvMask) <= 1), 32'd1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b1; stop[i] = 1'b0; con[i] = 1'b0; ir[i] = 32'd0;
        end
        #2;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset_hold", obs[0], 32'd0);
        end

        // Instance 0, MEM_LAT=1: add
        ir[0] = IrAdd;
        rst_n[0] = 1'b1;
        step();
        step_check("add_t0", 0, F0);
        step_check("add_t1", 0, F1);
        step_check("add_t2", 0, F2);
        step_check("add_t3", 0, T3 | SGrb | SROut | SYIn);
        step_check("add_t4", 0, T4 | SGrc | SROut | SZIn);
        step_check("add_t5", 0, T5 | SZloOut | SGra | SRIn);

        // brx not taken, then taken
        ir[0] = IrBrx;
        con[0] = 1'b0;
        step_check("brx0_t0", 0, F0);
        step_check("brx0_t1", 0, F1);
        step_check("brx0_t2", 0, F2);
        step_check("brx0_t3", 0, T3 | SGra | SROut | SConIn);
        step_check("brx0_t4", 0, T4 | SPcOut | SYIn);
        step_check("brx0_t5", 0, T5 | SCOut | SZIn);
        step_check("brx0_t6", 0, T6);
        con[0] = 1'b1;
        step_check("brx1_t0", 0, F0);
        step_check("brx1_t1", 0, F1);
        step_check("brx1_t2", 0, F2);
        step_check("brx1_t3", 0, T3 | SGra | SROut | SConIn);
        step_check("brx1_t4", 0, T4 | SPcOut | SYIn);
        step_check("brx1_t5", 0, T5 | SCOut | SZIn);
        step_check("brx1_t6", 0, T6 | SZloOut | SPcIn);

        // add with Stop rising mid-instruction: completes, then parks
        ir[0] = IrAdd;
        step_check("adds_t0", 0, F0);
        step_check("adds_t1", 0, F1);
        step_check("adds_t2", 0, F2);
        step_check("adds_t3", 0, T3 | SGrb | SROut | SYIn);
        stop[0] = 1'b1;
        step_check("adds_t4", 0, T4 | SGrc | SROut | SZIn);
        step_check("adds_t5", 0, T5 | SZloOut | SGra | SRIn);
        step_check("adds_idle0", 0, Idle);
        step_check("adds_idle1", 0, Idle);
        stop[0] = 1'b0;
        step();

        // nop: T2 straight back to T0
        ir[0] = IrNop;
        step_check("nop_t0", 0, F0);
        step_check("nop_t1", 0, F1);
        step_check("nop_t2", 0, F2);

        // jal, then halt
        ir[0] = IrJal;
        step_check("jal_t0", 0, F0);
        step_check("jal_t1", 0, F1);
        step_check("jal_t2", 0, F2);
        step_check("jal_t3", 0, T3 | SPcOut | SGrb | SRIn);
        step_check("jal_t4", 0, T4 | SGra | SROut | SPcIn);
        ir[0] = IrHalt;
        step_check("halt_t0", 0, F0);
        step_check("halt_t1", 0, F1);
        step_check("halt_t2", 0, F2);
        step_check("halt_t3", 0, T3);
        step_check("halt_state", 0, 32'd0);
        stop[0] = 1'b1;
        step_check("halt_stop1", 0, 32'd0);
        stop[0] = 1'b0;
        step_check("halt_stop0", 0, 32'd0);
        rst_n[0] = 1'b0;
        #1;
        check("halt_reset", obs[0], 32'd0);
        rst_n[0] = 1'b1;
        step();
        check("halt_reset_exit", obs[0], F0);
        rst_n[0] = 1'b0;

        // Instance 1, MEM_LAT=3: ld
        ir[1] = IrLd;
        rst_n[1] = 1'b1;
        step();
        step_check("ld_t0", 1, F0);
        step_check("ld_t1a", 1, F1);
        step_check("ld_t1b", 1, F1h);
        step_check("ld_t1c", 1, F1h);
        step_check("ld_t2", 1, F2);
        step_check("ld_t3", 1, T3 | SGrb | SBaOut | SYIn);
        step_check("ld_t4", 1, T4 | SCOut | SZIn);
        step_check("ld_t5", 1, T5 | SZloOut | SMarIn);
        step_check("ld_t6a", 1, T6 | SRead | SMdrIn);
        step_check("ld_t6b", 1, T6 | SRead | SMdrIn);
        step_check("ld_t6c", 1, T6 | SRead | SMdrIn);
        step_check("ld_t7", 1, T7 | SMdrOut | SGra | SRIn);
        check("ld_next", obs[1], F0);
        rst_n[1] = 1'b0;

        // Instance 2, MEM_LAT=4: st aborted by reset in T7
        ir[2] = IrSt;
        rst_n[2] = 1'b1;
        step();
        step_check("st_t0", 2, F0);
        step_check("st_t1a", 2, F1);
        step_check("st_t1b", 2, F1h);
        step_check("st_t1c", 2, F1h);
        step_check("st_t1d", 2, F1h);
        step_check("st_t2", 2, F2);
        step_check("st_t3", 2, T3 | SGrb | SBaOut | SYIn);
        step_check("st_t4", 2, T4 | SCOut | SZIn);
        step_check("st_t5", 2, T5 | SZloOut | SMarIn);
        step_check("st_t6", 2, T6 | SGra | SROut | SMdrIn);
        step_check("st_t7a", 2, T7 | SWrite);
        check("st_t7b", obs[2], T7 | SWrite);
        rst_n[2] = 1'b0;
        #1;
        check("st_abort", obs[2], 32'd0);
        step_check("st_abort_hold0", 2, 32'd0);
        check("st_abort_hold1", obs[2], 32'd0);

        // Release with Stop=1 parks in IDLE until Stop drops
        stop[2] = 1'b1;
        rst_n[2] = 1'b1;
        step();
        step_check("idle_park0", 2, Idle);
        check("idle_park1", obs[2], Idle);
        stop[2] = 1'b0;
        step();
        check("idle_exit", obs[2], F0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
